// File: rtl/lsu_wb_pkg.sv
// Shared constants, FSM state type and helpers for the LSU VGPR writeback path.
package lsu_wb_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WFID_W = 6;
  localparam int unsigned LANES  = 64;
  localparam int unsigned MAX_DW = 4;
  localparam int unsigned DW_W   = LANES * 32;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } lsu_wb_state_e;

  function automatic logic ndw_legal(input logic [CNT_W-1:0] n);
    return (n != '0) && (n <= CNT_W'(MAX_DW));
  endfunction

  // Illegal dword counts collapse to a full four-dword request.
  function automatic logic [CNT_W-1:0] ndw_norm(input logic [CNT_W-1:0] n);
    return ndw_legal(n) ? n : CNT_W'(MAX_DW);
  endfunction

  function automatic logic [MAX_DW-1:0] wr_en_dec(input logic [CNT_W-1:0] n);
    case (n)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_wb_assembler.sv
// Four-dword beat assembly register; a first beat clears the stale dwords.
module lsu_wb_assembler
  import lsu_wb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic                   clear,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DW_W-1:0]        din,
  output logic [MAX_DW*DW_W-1:0] merged
);

  logic [DW_W-1:0] dw_q [MAX_DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MAX_DW; k++) dw_q[k] <= '0;
    end else if (wr) begin
      for (int unsigned k = 0; k < MAX_DW; k++) begin
        if (idx == IDX_W'(k)) dw_q[k] <= din;
        else if (clear)       dw_q[k] <= '0;
      end
    end
  end

  // View including the beat being accepted this cycle, so the final beat
  // can be captured into the output register on the same edge.
  always_comb begin
    merged = '0;
    for (int unsigned k = 0; k < MAX_DW; k++) begin
      if (wr && idx == IDX_W'(k)) merged[k*DW_W +: DW_W] = din;
      else if (wr && clear)       merged[k*DW_W +: DW_W] = '0;
      else                        merged[k*DW_W +: DW_W] = dw_q[k];
    end
  end

endmodule

// File: rtl/lsu_vgpr_writeback.sv
// Collects 1..4 load-return beats per request and issues one VGPR write.
// Optional protocol/range checker enabled by defining LSU_WB_CHECK_EN.
module lsu_vgpr_writeback
  import lsu_wb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat_valid,
  output logic                     beat_ready,
  input  logic                     beat_first,
  input  logic [WFID_W-1:0]        beat_wfid,
  input  logic [ADDR_W-1:0]        beat_dest_addr,
  input  logic [CNT_W-1:0]         beat_ndw,
  input  logic [LANES-1:0]         beat_exec_mask,
  input  logic [DW_W-1:0]          beat_data,
  output logic [ADDR_W-1:0]        lsu_dest_addr,
  output logic [MAX_DW*DW_W-1:0]   lsu_dest_data,
  output logic [LANES-1:0]         lsu_dest_wr_mask,
  output logic [MAX_DW-1:0]        lsu_dest_wr_en,
  output logic                     lsu_instr_done,
  output logic [WFID_W-1:0]        lsu_instr_done_wfid,
  output logic                     wb_error
);

  lsu_wb_state_e             state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          hdr_ndw_q;
  logic [ADDR_W-1:0]         hdr_addr_q;
  logic [WFID_W-1:0]         hdr_wfid_q;
  logic [LANES-1:0]          hdr_mask_q;
  logic                      accept, hdr_load, last_beat;
  logic                      asm_wr, asm_clear;
  logic [IDX_W-1:0]          asm_idx;
  logic [CNT_W-1:0]          in_ndw;
  logic [MAX_DW*DW_W-1:0]    asm_data;

  assign in_ndw = ndw_norm(beat_ndw);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_load   = 1'b0;
    last_beat  = 1'b0;
    beat_ready = (state_q != WRITE);
    accept     = beat_valid && beat_ready;
    case (state_q)
      IDLE: begin
        if (accept && beat_first) begin
          hdr_load = 1'b1;
          cnt_d    = CNT_W'(1);
          if (in_ndw == CNT_W'(1)) begin
            state_d   = WRITE;
            last_beat = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept && beat_first) begin
          hdr_load = 1'b1;
          cnt_d    = CNT_W'(1);
          if (in_ndw == CNT_W'(1)) begin
            state_d   = WRITE;
            last_beat = 1'b1;
          end
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == hdr_ndw_q) begin
            state_d   = WRITE;
            last_beat = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A beat is stored on any accepted first beat, or any accepted beat in COLLECT.
  assign asm_wr    = accept && (beat_first || state_q == COLLECT);
  assign asm_clear = accept && beat_first;
  assign asm_idx   = beat_first ? '0 : cnt_q[IDX_W-1:0];

  lsu_wb_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .wr     (asm_wr),
    .clear  (asm_clear),
    .idx    (asm_idx),
    .din    (beat_data),
    .merged (asm_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      hdr_ndw_q           <= '0;
      hdr_addr_q          <= '0;
      hdr_wfid_q          <= '0;
      hdr_mask_q          <= '0;
      lsu_dest_addr       <= '0;
      lsu_dest_data       <= '0;
      lsu_dest_wr_mask    <= '0;
      lsu_dest_wr_en      <= '0;
      lsu_instr_done      <= 1'b0;
      lsu_instr_done_wfid <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lsu_dest_wr_en <= '0;
      lsu_instr_done <= 1'b0;
      if (hdr_load) begin
        hdr_ndw_q  <= in_ndw;
        hdr_addr_q <= beat_dest_addr;
        hdr_wfid_q <= beat_wfid;
        hdr_mask_q <= beat_exec_mask;
      end
      // Header fields bypass the header regs when the last beat is also the first.
      if (last_beat) begin
        lsu_dest_wr_en      <= wr_en_dec(hdr_load ? in_ndw : hdr_ndw_q);
        lsu_instr_done      <= 1'b1;
        lsu_dest_addr       <= hdr_load ? beat_dest_addr : hdr_addr_q;
        lsu_dest_wr_mask    <= hdr_load ? beat_exec_mask : hdr_mask_q;
        lsu_instr_done_wfid <= hdr_load ? beat_wfid : hdr_wfid_q;
        lsu_dest_data       <= asm_data;
      end
    end
  end

`ifdef LSU_WB_CHECK_EN
  logic            err_d;
  logic [ADDR_W:0] last_addr;

  // Top bit of the widened sum flags a request running past the last VGPR.
  always_comb begin
    last_addr = {1'b0, beat_dest_addr} + (ADDR_W+1)'(in_ndw) - (ADDR_W+1)'(1);
    err_d     = 1'b0;
    if (accept) begin
      if (beat_first) begin
        if (!ndw_legal(beat_ndw) || last_addr[ADDR_W]) err_d = 1'b1;
        if (state_q == COLLECT)                         err_d = 1'b1;
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        wb_error <= 1'b0;
    else if (err_d) wb_error <= 1'b1;
  end
`else
  assign wb_error = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_vgpr_writeback.sv
// Self-checking bench for lsu_vgpr_writeback: vector table plus scoreboard of expected writes.
module tb_lsu_vgpr_writeback;

  localparam int unsigned DW     = 2048;
  localparam int unsigned DATA_W = 4 * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              beat_valid, beat_ready, beat_first;
  logic [5:0]        beat_wfid;
  logic [9:0]        beat_dest_addr;
  logic [2:0]        beat_ndw;
  logic [63:0]       beat_exec_mask;
  logic [DW-1:0]     beat_data;
  logic [9:0]        lsu_dest_addr;
  logic [DATA_W-1:0] lsu_dest_data;
  logic [63:0]       lsu_dest_wr_mask;
  logic [3:0]        lsu_dest_wr_en;
  logic              lsu_instr_done;
  logic [5:0]        lsu_instr_done_wfid;
  logic              wb_error;

  always #5 clk = ~clk;

  lsu_vgpr_writeback dut (
    .clk                 (clk),
    .rst                 (rst),
    .beat_valid          (beat_valid),
    .beat_ready          (beat_ready),
    .beat_first          (beat_first),
    .beat_wfid           (beat_wfid),
    .beat_dest_addr      (beat_dest_addr),
    .beat_ndw            (beat_ndw),
    .beat_exec_mask      (beat_exec_mask),
    .beat_data           (beat_data),
    .lsu_dest_addr       (lsu_dest_addr),
    .lsu_dest_data       (lsu_dest_data),
    .lsu_dest_wr_mask    (lsu_dest_wr_mask),
    .lsu_dest_wr_en      (lsu_dest_wr_en),
    .lsu_instr_done      (lsu_instr_done),
    .lsu_instr_done_wfid (lsu_instr_done_wfid),
    .wb_error            (wb_error)
  );

  typedef struct {
    logic [5:0]  wfid;
    logic [9:0]  addr;
    logic [2:0]  ndw;
    logic [63:0] mask;
    logic [7:0]  seed;
    logic [3:0]  exp_wr_en;
  } vec_t;

  typedef struct {
    logic [3:0]        wr_en;
    logic [9:0]        addr;
    logic [5:0]        wfid;
    logic [63:0]       mask;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic err_model = 1'b0;

  function automatic logic [DW-1:0] gen_data(input logic [7:0] seed, input int unsigned k);
    logic [DW-1:0] r;
    for (int unsigned i = 0; i < 64; i++) r[32*i +: 32] = {seed, 8'(k), 16'(i*37 + 5)};
    return r;
  endfunction

  function automatic int unsigned norm(input logic [2:0] n);
    return (n == 3'd0 || n > 3'd4) ? 4 : int'(n);
  endfunction

  function automatic logic exp_err();
`ifdef LSU_WB_CHECK_EN
    return err_model;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      for (int unsigned k = 0; k < 4; k++) begin
        if (act[k*DW +: DW] !== req[k*DW +: DW]) begin
          $display("FAIL %s: dword %0d differs, low64 got %h expected %h (t=%0t)",
                   name, k, act[k*DW +: 64], req[k*DW +: 64], $time);
          break;
        end
      end
    end
  endtask

  task automatic push_exp(input logic [3:0] wr_en, input logic [9:0] addr, input logic [5:0] wfid,
                          input logic [63:0] mask, input int unsigned nd, input logic [7:0] seed);
    exp_t e;
    e.wr_en = wr_en;
    e.addr  = addr;
    e.wfid  = wfid;
    e.mask  = mask;
    e.data  = '0;
    for (int unsigned k = 0; k < nd; k++) e.data[k*DW +: DW] = gen_data(seed, k);
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for beat_ready, then holds the beat across one accepting edge.
  task automatic put_beat(input logic first, input logic [5:0] wfid, input logic [9:0] addr,
                          input logic [2:0] ndw, input logic [63:0] mask, input logic [DW-1:0] data);
    beat_first     = first;
    beat_wfid      = wfid;
    beat_dest_addr = addr;
    beat_ndw       = ndw;
    beat_exec_mask = mask;
    beat_data      = data;
    beat_valid     = 1'b1;
    for (int t = 0; t < 16 && !beat_ready; t++) begin
      @(posedge clk); #1;
    end
    if (!beat_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: beat_ready stuck at 0, required 1 (t=%0t)", $time);
    end
    @(posedge clk); #1;
    beat_valid = 1'b0;
    beat_first = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Non-first beats carry scrambled header fields that must be ignored.
  task automatic send_req(input logic [5:0] wfid, input logic [9:0] addr, input logic [2:0] ndw,
                          input logic [63:0] mask, input logic [7:0] seed, input int gap,
                          input logic [3:0] exp_wr_en);
    int unsigned nd;
    nd = norm(ndw);
    if (ndw == 3'd0 || ndw > 3'd4) err_model = 1'b1;
    if (int'(addr) + int'(nd) - 1 > 1023) err_model = 1'b1;
    for (int unsigned k = 0; k < nd; k++) begin
      if (k == nd - 1) push_exp(exp_wr_en, addr, wfid, mask, nd, seed);
      if (k == 0) put_beat(1'b1, wfid, addr, ndw, mask, gen_data(seed, k));
      else        put_beat(1'b0, ~wfid, ~addr, ~ndw, ~mask, gen_data(seed, k));
      if (k != nd - 1) idle(gap);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    beat_valid = 1'b0;
    rst        = 1'b1;
    #1;
    chk({tag, "_wr_en"}, 64'(lsu_dest_wr_en), 64'd0);
    chk({tag, "_done"},  64'(lsu_instr_done), 64'd0);
    chk({tag, "_addr"},  64'(lsu_dest_addr), 64'd0);
    chk({tag, "_wfid"},  64'(lsu_instr_done_wfid), 64'd0);
    chk({tag, "_mask"},  lsu_dest_wr_mask, 64'd0);
    chk({tag, "_ready"}, 64'(beat_ready), 64'd1);
    chk({tag, "_err"},   64'(wb_error), 64'd0);
    chk_data({tag, "_data"}, lsu_dest_data, '0);
    err_model = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (lsu_instr_done || lsu_dest_wr_en != 4'b0)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: wr_en=%b done=%b addr=%0d, required no write (t=%0t)",
                 lsu_dest_wr_en, lsu_instr_done, lsu_dest_addr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_en", 64'(lsu_dest_wr_en), 64'(e.wr_en));
        chk("done", 64'(lsu_instr_done), 64'd1);
        chk("addr", 64'(lsu_dest_addr), 64'(e.addr));
        chk("wfid", 64'(lsu_instr_done_wfid), 64'(e.wfid));
        chk("mask", lsu_dest_wr_mask, e.mask);
        chk("ready_in_write", 64'(beat_ready), 64'd0);
        chk_data("data", lsu_dest_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs [7];

  initial begin
    logic [DW-1:0]     d1;
    exp_t              e1;

    vecs[0] = '{6'd1,  10'd10,   3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h11, 4'b0001};
    vecs[1] = '{6'd2,  10'd20,   3'd2, 64'hAAAA_5555_AAAA_5555, 8'h12, 4'b0011};
    vecs[2] = '{6'd3,  10'd30,   3'd3, 64'h0123_4567_89AB_CDEF, 8'h13, 4'b0111};
    vecs[3] = '{6'd4,  10'd40,   3'd4, 64'h8000_0000_0000_0001, 8'h14, 4'b1111};
    vecs[4] = '{6'd63, 10'd1020, 3'd4, 64'h0F0F_0F0F_F0F0_F0F0, 8'h15, 4'b1111};
    vecs[5] = '{6'd7,  10'd5,    3'd0, 64'h0000_FFFF_0000_FFFF, 8'h16, 4'b1111};
    vecs[6] = '{6'd8,  10'd6,    3'd7, 64'hDEAD_BEEF_CAFE_F00D, 8'h17, 4'b1111};

    rst = 1'b1;
    beat_valid = 1'b0;
    beat_first = 1'b0;
    beat_wfid = '0;
    beat_dest_addr = '0;
    beat_ndw = '0;
    beat_exec_mask = '0;
    beat_data = '0;
    #12;
    chk("reset_wr_en", 64'(lsu_dest_wr_en), 64'd0);
    chk("reset_done", 64'(lsu_instr_done), 64'd0);
    chk("reset_ready", 64'(beat_ready), 64'd1);
    chk("reset_err", 64'(wb_error), 64'd0);
    chk_data("reset_data", lsu_dest_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: back-to-back requests; wb_error checked after each.
    foreach (vecs[i]) begin
      send_req(vecs[i].wfid, vecs[i].addr, vecs[i].ndw, vecs[i].mask, vecs[i].seed, 0, vecs[i].exp_wr_en);
      chk("table_err", 64'(wb_error), 64'(exp_err()));
    end
    drain();

    do_reset("rst_a");

    // Single dword, then check the write lasts one cycle and outputs hold.
    d1 = '0;
    d1[31:0] = 32'hffff0000;
    e1.wr_en = 4'b0001;
    e1.addr  = 10'd50;
    e1.wfid  = 6'd5;
    e1.mask  = 64'h1;
    e1.data  = '0;
    e1.data[31:0] = 32'hffff0000;
    exp_q.push_back(e1);
    put_beat(1'b1, 6'd5, 10'd50, 3'd1, 64'h1, d1);
    chk("single_wr_en_now", 64'(lsu_dest_wr_en), 64'b0001);
    @(posedge clk); #1;
    chk("single_wr_en_after", 64'(lsu_dest_wr_en), 64'd0);
    chk("single_done_after", 64'(lsu_instr_done), 64'd0);
    chk("single_addr_hold", 64'(lsu_dest_addr), 64'd50);
    chk("single_ready_after", 64'(beat_ready), 64'd1);

    // Quad back-to-back; write cycle blocks beats.
    send_req(6'd9, 10'd100, 3'd4, 64'hFFFF_0000_FFFF_0000, 8'h22, 0, 4'b1111);
    chk("quad_ready", 64'(beat_ready), 64'd0);
    chk("quad_wr_en", 64'(lsu_dest_wr_en), 64'b1111);

    // Gapped beats.
    send_req(6'd10, 10'd300, 3'd3, 64'h1234_5678_9ABC_DEF0, 8'h33, 2, 4'b0111);
    drain();
    chk("gapped_err", 64'(wb_error), 64'd0);

    // Stray non-first beat, then restart mid-collect.
    do_reset("rst_b");
    put_beat(1'b0, 6'd1, 10'd400, 3'd2, 64'hF, gen_data(8'h40, 0));
    err_model = 1'b1;
    idle(2);
    chk("stray_err", 64'(wb_error), 64'(exp_err()));
    do_reset("rst_c");
    put_beat(1'b1, 6'd20, 10'd200, 3'd4, 64'hFF, gen_data(8'h41, 0));
    put_beat(1'b0, 6'd20, 10'd200, 3'd4, 64'hFF, gen_data(8'h41, 1));
    chk("restart_err_before", 64'(wb_error), 64'd0);
    err_model = 1'b1;
    push_exp(4'b0001, 10'd7, 6'd11, 64'h00FF_00FF_00FF_00FF, 1, 8'h44);
    put_beat(1'b1, 6'd11, 10'd7, 3'd1, 64'h00FF_00FF_00FF_00FF, gen_data(8'h44, 0));
    drain();
    idle(3);
    chk("restart_err", 64'(wb_error), 64'(exp_err()));

    // Range overflow past the last VGPR.
    do_reset("rst_d");
    send_req(6'd12, 10'd1022, 3'd4, 64'hFFFF_FFFF_0000_0000, 8'h55, 0, 4'b1111);
    drain();
    chk("range_err", 64'(wb_error), 64'(exp_err()));

    // Async reset mid-collect after 2 of 4 beats.
    do_reset("rst_e");
    put_beat(1'b1, 6'd30, 10'd600, 3'd4, 64'hFFFF, gen_data(8'h66, 0));
    put_beat(1'b0, 6'd30, 10'd600, 3'd4, 64'hFFFF, gen_data(8'h66, 1));
    do_reset("rst_mid");
    send_req(6'd31, 10'd610, 3'd1, 64'h5, 8'h77, 0, 4'b0001);
    drain();
    idle(3);
    chk("post_reset_err", 64'(wb_error), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
